// File: rtl/write_pixels_pkg.sv
`default_nettype none
// ============================================================================
// Module      : write_pixels_pkg
// Description : Shared types and constants for the PMOD LED-array byte writer.
// Revision    : 1.0 - initial release
// ============================================================================
package write_pixels_pkg;

    localparam int c_HALF_PERIOD_DEFAULT = 6;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_BIT_LO   = 3'd2,
        ST_BIT_HI   = 3'd3,
        ST_STOP_LO  = 3'd4,
        ST_STOP_HI  = 3'd5,
        ST_STOP_END = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/write_pixels_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : write_pixels_phase_timer
// Description : Loadable down-counter; pulses o_phase_done on a phase's last cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module write_pixels_phase_timer #(
    parameter int HALF_PERIOD = 6
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic i_load,
    output logic o_phase_done
);

    localparam int               c_CW   = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [c_CW-1:0]  c_LOAD = c_CW'(HALF_PERIOD - 1);
    localparam logic [c_CW-1:0]  c_ONE  = c_CW'(1);

    logic [c_CW-1:0] r_cnt;
    logic            r_run;

    // A load on the done cycle restarts the count for the following phase.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (i_load) begin
            r_cnt <= c_LOAD;
            r_run <= 1'b1;
        end else if (r_run) begin
            if (r_cnt == '0) begin
                r_run <= 1'b0;
            end else begin
                r_cnt <= r_cnt - c_ONE;
            end
        end
    end

    assign o_phase_done = r_run && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/write_pixels.sv
`default_nettype none
// ============================================================================
// Module      : write_pixels
// Description : Byte-serial MSB-first writer with start/stop framing for the PMOD LED driver.
// Revision    : 1.0 - initial release
// ============================================================================
module write_pixels
    import write_pixels_pkg::*;
#(
    parameter int HALF_PERIOD = c_HALF_PERIOD_DEFAULT
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       VALID,
    input  logic [7:0] DATA,
    output logic       SCLK,
    output logic       SDIN,
    output logic       BUSY
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_idx;
    logic [2:0]  w_idx_nxt;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_nxt;
    logic        r_sclk;
    logic        r_sdin;
    logic        r_busy;
    logic        w_sclk_nxt;
    logic        w_sdin_nxt;
    logic        w_busy_nxt;
    logic        w_load;
    logic        w_phase_done;

    write_pixels_phase_timer #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_phase_timer (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .i_load       (w_load),
        .o_phase_done (w_phase_done)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
            r_idx   <= 3'd0;
            r_shift <= 8'd0;
            r_sclk  <= 1'b1;
            r_sdin  <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_sclk  <= w_sclk_nxt;
            r_sdin  <= w_sdin_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // Every transition into a timed phase reloads the timer.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_load      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (VALID) begin
                    w_state_nxt = ST_START;
                    w_shift_nxt = DATA;
                    w_load      = 1'b1;
                end
            end
            ST_START: begin
                if (w_phase_done) begin
                    w_state_nxt = ST_BIT_LO;
                    w_idx_nxt   = 3'd7;
                    w_load      = 1'b1;
                end
            end
            ST_BIT_LO: begin
                if (w_phase_done) begin
                    w_state_nxt = ST_BIT_HI;
                    w_load      = 1'b1;
                end
            end
            ST_BIT_HI: begin
                if (w_phase_done) begin
                    w_load = 1'b1;
                    if (r_idx == 3'd0) begin
                        w_state_nxt = ST_STOP_LO;
                    end else begin
                        w_state_nxt = ST_BIT_LO;
                        w_idx_nxt   = r_idx - 3'd1;
                        w_shift_nxt = {r_shift[6:0], 1'b0};
                    end
                end
            end
            ST_STOP_LO: begin
                if (w_phase_done) begin
                    w_state_nxt = ST_STOP_HI;
                    w_load      = 1'b1;
                end
            end
            ST_STOP_HI: begin
                if (w_phase_done) begin
                    w_state_nxt = ST_STOP_END;
                    w_load      = 1'b1;
                end
            end
            ST_STOP_END: begin
                if (w_phase_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register with it.
    always_comb begin
        w_sclk_nxt = 1'b1;
        w_sdin_nxt = 1'b1;
        w_busy_nxt = 1'b1;
        unique case (w_state_nxt)
            ST_IDLE: begin
                w_busy_nxt = 1'b0;
            end
            ST_START: begin
                w_sdin_nxt = 1'b0;
            end
            ST_BIT_LO: begin
                w_sclk_nxt = 1'b0;
                w_sdin_nxt = w_shift_nxt[7];
            end
            ST_BIT_HI: begin
                w_sdin_nxt = r_sdin;
            end
            ST_STOP_LO: begin
                w_sclk_nxt = 1'b0;
                w_sdin_nxt = 1'b0;
            end
            ST_STOP_HI: begin
                w_sdin_nxt = 1'b0;
            end
            ST_STOP_END: begin
                w_sdin_nxt = 1'b1;
            end
            default: begin
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    assign SCLK = r_sclk;
    assign SDIN = r_sdin;
    assign BUSY = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_write_pixels.sv
`default_nettype none
// ============================================================================
// Module      : tb_write_pixels
// Description : Scoreboard bench for write_pixels: driver queues bytes, monitor decodes the wire.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_write_pixels;

    localparam int HP = 2;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       VALID = 1'b0;
    logic [7:0] DATA = 8'h00;
    logic       SCLK;
    logic       SDIN;
    logic       BUSY;

    int checks = 0;
    int failures = 0;
    int frames = 0;
    logic [7:0] exp_q[$];

    write_pixels #(.HALF_PERIOD(HP)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .VALID (VALID),
        .DATA  (DATA),
        .SCLK  (SCLK),
        .SDIN  (SDIN),
        .BUSY  (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- monitor: decode frames from SCLK/SDIN ----------------
    bit         in_frame = 0;
    int         t = 0;
    int         nbits = 0;
    int         busy_cnt = 0;
    logic [7:0] shreg = 8'h00;
    logic       prev_sclk = 1'b1;
    logic       prev_sdin = 1'b1;

    always @(negedge CLK) begin
        if (!RST_N) begin
            in_frame  = 0;
            busy_cnt  = 0;
            prev_sclk = 1'b1;
            prev_sdin = 1'b1;
        end else begin
            if (BUSY) begin
                busy_cnt++;
            end else if (busy_cnt != 0) begin
                chk(busy_cnt == 20 * HP, "busy_width", busy_cnt, 20 * HP);
                busy_cnt = 0;
            end
            if (!in_frame) begin
                if (SCLK && prev_sclk && prev_sdin && !SDIN) begin
                    in_frame = 1;
                    t        = 0;
                    nbits    = 0;
                    shreg    = 8'h00;
                end else if (SCLK !== prev_sclk || SDIN !== prev_sdin) begin
                    chk(0, "idle_glitch", {SCLK, SDIN}, 3);
                end
            end else begin
                t++;
                if (SCLK && !prev_sclk && nbits < 8) begin
                    chk(t == (2 + 2 * nbits) * HP, "bit_rise_time", t, (2 + 2 * nbits) * HP);
                    shreg = {shreg[6:0], SDIN};
                    nbits++;
                end else if (SCLK && prev_sclk && SDIN !== prev_sdin) begin
                    if (nbits == 8 && SDIN && !prev_sdin) begin
                        chk(t == 19 * HP, "stop_time", t, 19 * HP);
                        if (exp_q.size() == 0) begin
                            chk(0, "unexpected_frame", shreg, 0);
                        end else begin
                            logic [7:0] e;
                            e = exp_q.pop_front();
                            chk(shreg == e, "frame_byte", shreg, e);
                        end
                        frames++;
                        in_frame = 0;
                    end else begin
                        chk(0, "sdin_while_sclk_high", SDIN, prev_sdin);
                    end
                end
            end
            prev_sclk = SCLK;
            prev_sdin = SDIN;
        end
    end

    // ---------------- driver ----------------
    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        @(negedge CLK);
        while (BUSY && n < budget) begin
            @(negedge CLK);
            n++;
        end
        if (BUSY) chk(0, "busy_timeout", n, budget);
    endtask

    task automatic send(input logic [7:0] b, input bit expect_frame);
        wait_idle(200);
        VALID = 1'b1;
        DATA  = b;
        if (expect_frame) exp_q.push_back(b);
        @(posedge CLK);
        #1;
        chk(BUSY == 1'b1, "accept_busy", BUSY, 1);
        chk(SDIN == 1'b0 && SCLK == 1'b1, "accept_start", {SCLK, SDIN}, 2);
        @(negedge CLK);
        VALID = 1'b0;
        DATA  = 8'hFF;
    endtask

    initial begin
        bit idle_ok;
        // reset values
        repeat (3) @(negedge CLK);
        chk(SCLK == 1'b1, "rst_sclk", SCLK, 1);
        chk(SDIN == 1'b1, "rst_sdin", SDIN, 1);
        chk(BUSY == 1'b0, "rst_busy", BUSY, 0);
        RST_N = 1'b1;
        idle_ok = 1;
        repeat (30) begin
            @(negedge CLK);
            if (!(SCLK && SDIN && !BUSY)) idle_ok = 0;
        end
        chk(idle_ok, "idle_after_reset", idle_ok, 1);

        // single byte
        send(8'hF1, 1);

        // busy rejection
        send(8'h00, 1);
        repeat (10) @(negedge CLK);
        VALID = 1'b1;
        DATA  = 8'h55;
        @(negedge CLK);
        VALID = 1'b0;
        wait_idle(200);
        idle_ok = 1;
        repeat (50) begin
            @(negedge CLK);
            if (BUSY || !SCLK || !SDIN) idle_ok = 0;
        end
        chk(idle_ok, "no_extra_frame", idle_ok, 1);

        // sequencer burst
        send(8'hF1, 1);
        for (int i = 0; i < 16; i++) begin
            send((i % 2 == 0) ? 8'h00 : 8'h55, 1);
        end

        // data changes to 0xFF right after acceptance inside send()
        send(8'hA5, 1);

        // reset during bit 3 low phase
        send(8'h5A, 0);
        repeat (9 * HP) @(negedge CLK);
        chk(SCLK == 1'b0 && BUSY == 1'b1, "pre_reset_bit_lo", {SCLK, BUSY}, 1);
        #1 RST_N = 1'b0;
        #1;
        chk(SCLK == 1'b1 && SDIN == 1'b1 && BUSY == 1'b0, "async_reset_idle",
            {SCLK, SDIN, BUSY}, 6);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        send(8'h3C, 1);
        wait_idle(200);
        repeat (5) @(negedge CLK);

        chk(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
        chk(frames == 21, "frame_count", frames, 21);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
